// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake between the command packetiser (master) and the
// buffered UART transmitter (slave).
interface uart_tx_fifo_if #(
  parameter int BITS_N = 8
);
  logic [BITS_N-1:0] data_tx;
  logic              valid;
  logic              ready;

  modport master (output data_tx, output valid, input ready);
  modport slave  (input data_tx, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and are serialised
// back-to-back (start, data LSB first, optional parity, stop bits).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 tx_if,
  output logic                          uart_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  // state    | meaning
  // S_IDLE   | line high, waiting for a queued word
  // S_START  | start bit (low)
  // S_DATA   | data bits, LSB first
  // S_PARITY | parity bit, only when PARITY_TYPE != 0
  // S_STOP   | STOP_BITS stop bits (high); may chain straight into S_START

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(BITS_N);

  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(BITS_N - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [BITS_N-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [BITS_N-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              out_q, out_d;
  logic              push, pop, load;
  logic              baud_end, have_word;
  logic [BITS_N-1:0] head;

  assign head        = mem_q[rd_ptr_q];
  assign tx_if.ready = (count_q != FULL);
  assign push        = tx_if.valid && tx_if.ready;
  assign baud_end    = (baud_q == BAUD_LAST);
  assign have_word   = (count_q != '0);
  assign pop         = load;

  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign wr_ptr_d = wr_ptr_q + AW'(push);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    out_d   = out_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        out_d = 1'b1;
        if (have_word) load = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          out_d   = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (PARITY_TYPE != 0) begin
              state_d = S_PARITY;
              out_d   = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              out_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            out_d   = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
          stop_d  = 1'b0;
          out_d   = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            // chain the next queued word without an idle gap
            if (have_word) load = 1'b1;
            else           state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
      end
    endcase

    if (load) begin
      shreg_d = head;
      par_d   = (PARITY_TYPE == 1) ? ~^head : ^head;
      state_d = S_START;
      baud_d  = '0;
      out_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_if.data_tx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      out_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      out_q    <= out_d;
    end
  end

  assign uart_out   = out_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;
endmodule
